axis_packet_generator: RTL and testbench

AXI4-Stream traffic source for CMAC loopback and throughput testing. It emits fixed-length packets carrying a sequence number and beat index, with a programmable inter-packet gap and packet count. Its output stream drives the CMAC TX path, and that path is tapped by the packet-counter probes. Software starts and stops it through plain control ports and reads back progress counters.

---
 rtl/axis_packet_generator.sv | 170 +++++++++++++++++
 tb/tb_axis_packet_generator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_generator.sv
// AXI4-Stream fixed-length packet source with sequence/beat tagging, gap and count control.
// Optional PKTGEN_STALL_STATS_EN adds a saturating stall_count output.
module axis_packet_generator #(
    parameter int DWIDTH    = 512,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] pkt_len_beats,
    input  logic [31:0]          pkt_count,
    input  logic [7:0]           gap_cycles,
    output logic                 out_axis_tvalid,
    input  logic                 out_axis_tready,
    output logic [DWIDTH-1:0]    out_axis_tdata,
    output logic                 out_axis_tlast,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          sent_count
`ifdef PKTGEN_STALL_STATS_EN
    ,
    output logic [31:0]          stall_count
`endif
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] last_q, last_d;
    logic [LEN_WIDTH-1:0] beat_q, beat_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          seq_q, seq_d;
    logic [31:0]          sent_q, sent_d;
    logic [7:0]           gap_q, gap_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
    logic                 tlast_q, tlast_d;
    logic                 hs, stop_seen;
`ifdef PKTGEN_STALL_STATS_EN
    logic [31:0]          stall_q, stall_d;
`endif

    assign hs        = (state_q == SEND) && out_axis_tready;
    assign stop_seen = stop_q || stop;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        sent_d    = sent_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    // a zero length is promoted to a single-beat packet
                    last_d  = (pkt_len_beats == '0) ? '0 : pkt_len_beats - LEN_WIDTH'(1);
                    cnt_d   = pkt_count;
                    gap_d   = gap_cycles;
                    seq_d   = '0;
                    beat_d  = '0;
                    sent_d  = '0;
                    stop_d  = stop;
                end
            end
            SEND: begin
                stop_d = stop_seen;
                if (hs) begin
                    if (beat_q == last_q) begin
                        sent_d = sent_q + 32'd1;
                        seq_d  = seq_q + 32'd1;
                        beat_d = '0;
                        if (stop_seen || (cnt_q != '0 && (sent_q + 32'd1) == cnt_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            stop_d  = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                stop_d = stop_seen;
                if (stop_seen) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else if (gap_cnt_q <= 8'd1) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // tlast is registered from next-state so no path from tready reaches it
        tlast_d = (state_d == SEND) && (beat_d == last_d);
    end

`ifdef PKTGEN_STALL_STATS_EN
    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start)
            stall_d = '0;
        else if (state_q == SEND && !out_axis_tready && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            last_q    <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            seq_q     <= '0;
            sent_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            tlast_q   <= 1'b0;
`ifdef PKTGEN_STALL_STATS_EN
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            sent_q    <= sent_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            tlast_q   <= tlast_d;
`ifdef PKTGEN_STALL_STATS_EN
            stall_q   <= stall_d;
`endif
        end
    end

    always_comb begin
        out_axis_tdata        = '0;
        out_axis_tdata[31:0]  = seq_q;
        out_axis_tdata[63:32] = 32'(beat_q);
    end

    assign out_axis_tvalid = (state_q == SEND);
    assign out_axis_tlast  = tlast_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign sent_count      = sent_q;
`ifdef PKTGEN_STALL_STATS_EN
    assign stall_count     = stall_q;
`endif

endmodule

// File: tb/tb_axis_packet_generator.sv
// Randomized bench for axis_packet_generator: expected beat stream is built from the
// packet rules (seq/beat per packet, gap length, stop point) and compared handshake by handshake.
module tb_axis_packet_generator;

    localparam int DWIDTH    = 512;
    localparam int LEN_WIDTH = 16;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 start;
    logic                 stop;
    logic [LEN_WIDTH-1:0] pkt_len_beats;
    logic [31:0]          pkt_count;
    logic [7:0]           gap_cycles;
    logic                 out_axis_tvalid;
    logic                 out_axis_tready;
    logic [DWIDTH-1:0]    out_axis_tdata;
    logic                 out_axis_tlast;
    logic                 busy;
    logic                 done;
    logic [31:0]          sent_count;
`ifdef PKTGEN_STALL_STATS_EN
    logic [31:0]          stall_count;
`endif

    int checks = 0;
    int errors = 0;

    axis_packet_generator #(.DWIDTH(DWIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .start           (start),
        .stop            (stop),
        .pkt_len_beats   (pkt_len_beats),
        .pkt_count       (pkt_count),
        .gap_cycles      (gap_cycles),
        .out_axis_tvalid (out_axis_tvalid),
        .out_axis_tready (out_axis_tready),
        .out_axis_tdata  (out_axis_tdata),
        .out_axis_tlast  (out_axis_tlast),
        .busy            (busy),
        .done            (done),
        .sent_count      (sent_count)
`ifdef PKTGEN_STALL_STATS_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    always #5 aclk = ~aclk;

    // Launches one run and follows it cycle by cycle against the packet rules.
    // stop_pkt >= 0 raises stop while beat stop_beat of packet stop_pkt is shown;
    // stop_beat < 0 raises stop together with start.
    task automatic stream_check(input string name, input int len, input int count, input int gap,
                                input int rdy_pct, input int stop_pkt, input int stop_beat);
        int L, n_exp, p, b, idle_run, stalls, cyc;
        bit prev_stall, stop_sent, fin, got_done, hs;
        logic [DWIDTH-1:0] prev_data;
        logic prev_last;
        L = (len == 0) ? 1 : len;
        n_exp = (stop_pkt >= 0) ? stop_pkt + 1 : count;
        p = 0; b = 0; idle_run = 0; stalls = 0; cyc = 0;
        prev_stall = 0; stop_sent = 0; fin = 0; got_done = 0;
        prev_data = '0; prev_last = 1'b0;

        @(negedge aclk);
        pkt_len_beats = LEN_WIDTH'(len);
        pkt_count     = 32'(count);
        gap_cycles    = 8'(gap);
        start         = 1'b1;
        out_axis_tready = 1'b1;
        if (stop_pkt >= 0 && stop_beat < 0) begin
            stop = 1'b1;
            stop_sent = 1;
        end
        @(negedge aclk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (out_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_latency: tvalid=%b busy=%b, required 1 1", name, out_axis_tvalid, busy);
        end

        while (!got_done && cyc < 5000) begin
            start = 1'b0;
            stop  = 1'b0;
            checks++;
            if (sent_count !== 32'(p)) begin
                errors++;
                $display("FAIL %s sent_count: got %0d, required %0d", name, sent_count, p);
            end
            if (fin) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || out_axis_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_pulse: done=%b busy=%b tvalid=%b, required 1 0 0",
                             name, done, busy, out_axis_tvalid);
                end
                got_done = 1;
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_done: done=%b, required 0 (pkt %0d beat %0d)", name, done, p, b);
                end
                if (prev_stall) begin
                    checks++;
                    if (out_axis_tvalid !== 1'b1 || out_axis_tdata !== prev_data || out_axis_tlast !== prev_last) begin
                        errors++;
                        $display("FAIL %s stall_stability: tvalid=%b tlast=%b data_lo=%h, required 1 %b %h",
                                 name, out_axis_tvalid, out_axis_tlast, out_axis_tdata[63:0], prev_last, prev_data[63:0]);
                    end
                end
                if (out_axis_tvalid === 1'b1) begin
                    if (b == 0 && p > 0) begin
                        checks++;
                        if (idle_run != gap) begin
                            errors++;
                            $display("FAIL %s gap_length: got %0d idle cycles, required %0d", name, idle_run, gap);
                        end
                    end
                    checks++;
                    if (out_axis_tdata[31:0] !== 32'(p) || out_axis_tdata[63:32] !== 32'(b) ||
                        (out_axis_tdata >> 64) !== '0 || out_axis_tlast !== (b == L - 1)) begin
                        errors++;
                        $display("FAIL %s beat: seq=%0d beat=%0d tlast=%b, required seq=%0d beat=%0d tlast=%b",
                                 name, out_axis_tdata[31:0], out_axis_tdata[63:32], out_axis_tlast, p, b, (b == L - 1));
                    end
                    if (stop_pkt >= 0 && !stop_sent && p == stop_pkt && b == stop_beat) begin
                        stop = 1'b1;
                        stop_sent = 1;
                    end
                end else begin
                    idle_run++;
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy_in_gap: busy=%b, required 1", name, busy);
                    end
                end
                out_axis_tready = (int'($urandom_range(0, 99)) < rdy_pct);
                // mid-run config churn and stray starts must be ignored
                pkt_len_beats = LEN_WIDTH'($urandom);
                pkt_count     = $urandom;
                gap_cycles    = 8'($urandom);
                start         = ($urandom_range(0, 7) == 0);
                hs = (out_axis_tvalid === 1'b1) && out_axis_tready;
                prev_stall = (out_axis_tvalid === 1'b1) && !out_axis_tready;
                if (prev_stall) stalls++;
                prev_data = out_axis_tdata;
                prev_last = out_axis_tlast;
                if (hs) begin
                    if (b == L - 1) begin
                        p++;
                        b = 0;
                        idle_run = 0;
                        if (p == n_exp) fin = 1;
                    end else begin
                        b++;
                    end
                end
                @(negedge aclk);
                cyc++;
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no completion after %0d cycles, %0d of %0d packets", name, cyc, p, n_exp);
        end
`ifdef PKTGEN_STALL_STATS_EN
        checks++;
        if (stall_count !== 32'(stalls)) begin
            errors++;
            $display("FAIL %s stall_count: got %0d, required %0d", name, stall_count, stalls);
        end
`endif
        start = 1'b0;
        stop  = 1'b0;
        out_axis_tready = 1'b1;
        @(negedge aclk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sent_count !== 32'(n_exp)) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b sent=%0d, required 0 0 %0d",
                     name, done, busy, sent_count, n_exp);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        pkt_len_beats = '0;
        pkt_count = '0;
        gap_cycles = '0;
        out_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if (out_axis_tvalid !== 1'b0 || out_axis_tlast !== 1'b0 || out_axis_tdata !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || sent_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: tvalid=%b tlast=%b busy=%b done=%b sent=%0d, required all 0",
                     out_axis_tvalid, out_axis_tlast, busy, done, sent_count);
        end
`ifdef PKTGEN_STALL_STATS_EN
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_count: got %0d, required 0", stall_count);
        end
`endif
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_basic();
        stream_check("basic", 4, 3, 0, 100, -1, 0);
    endtask

    task automatic test_gap();
        stream_check("gap5", 2, 2, 5, 100, -1, 0);
        stream_check("gap_rand", 3, 3, 1 + int'($urandom_range(0, 6)), 70, -1, 0);
    endtask

    task automatic test_random_ready();
        stream_check("rand_ready", 8, 10, 0, 50, -1, 0);
        stream_check("rand_ready_gap", 5, 4, 3, 50, -1, 0);
    endtask

    task automatic test_stop();
        stream_check("stop_continuous", 3, 0, 0, 100, 5, 1);
        stream_check("stop_with_start", 4, 0, 2, 100, 0, -1);
    endtask

    task automatic test_len_zero();
        stream_check("len_zero", 0, 1, 0, 100, -1, 0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit hit;
        cyc = 0;
        hit = 0;
        @(negedge aclk);
        pkt_len_beats = 16'd4;
        pkt_count = 32'd3;
        gap_cycles = 8'd0;
        out_axis_tready = 1'b1;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        // reset while beat 2 of the second packet is on the bus
        while (!hit && cyc < 50) begin
            if (out_axis_tvalid === 1'b1 && out_axis_tdata[31:0] === 32'd1 && out_axis_tdata[63:32] === 32'd2) begin
                hit = 1;
                areset = 1'b1;
            end
            @(negedge aclk);
            cyc++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_timeout: beat 2 of packet 1 never presented");
        end
        checks++;
        if (out_axis_tvalid !== 1'b0 || busy !== 1'b0 || sent_count !== 32'd0 ||
            out_axis_tlast !== 1'b0 || out_axis_tdata !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tvalid=%b busy=%b sent=%0d tlast=%b done=%b, required all 0",
                     out_axis_tvalid, busy, sent_count, out_axis_tlast, done);
        end
        areset = 1'b0;
        @(negedge aclk);
        stream_check("after_reset", 4, 2, 1, 100, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_random_ready();
        test_stop();
        test_len_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
